flit_output_arbiter: RTL and testbench

//   Round-robin arbiter sharing one router output channel among NUM_PORTS input ports.

---
 rtl/flit_output_arbiter_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 29 ++
 rtl/flit_output_arbiter.sv | 129 ++++++++++++
 tb/tb_flit_output_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_output_arbiter_pkg.sv
// Shared types and helpers for the flit output arbiter and related allocators.
package flit_output_arbiter_pkg;

   // Arbiter FSM: waiting for a request, or holding a grant for a packet.
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

   // Default watchdog limit for a stalled packet, in cycles.
   localparam int unsigned ARB_DEFAULT_TIMEOUT = 256;

   // Round-robin successor of a port index, wrapping at n.
   function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans req starting at ptr and returns the
// first requesting index. Shared with the VC allocator.
module rr_priority_picker #(
   parameter int unsigned NUM_PORTS = 4,
   localparam int unsigned IDX_W = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [IDX_W-1:0]     winner,
   output logic                 any_req
);

   logic [IDX_W-1:0] cand;

   // First hit in the rotated scan wins; later hits are ignored.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cand = IDX_W'((32'(ptr) + i) % NUM_PORTS);
         if (!any_req && req[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/flit_output_arbiter.sv
// Round-robin output-channel arbiter. Locks one input port for a whole packet
// (head through tail), forwards its flits over valid/ready, and force-releases
// the lock if the packet stalls for TIMEOUT_CYC cycles.
module flit_output_arbiter
   import flit_output_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS   = 4,
   parameter int unsigned FLIT_WIDTH  = 64,
   parameter int unsigned TIMEOUT_CYC = ARB_DEFAULT_TIMEOUT,
   localparam int unsigned IDX_W      = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            in_valid,
   input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [NUM_PORTS-1:0]            in_tail,
   output logic [NUM_PORTS-1:0]            in_ready,
   output logic                            out_valid,
   output logic [FLIT_WIDTH-1:0]           out_flit,
   output logic                            out_tail,
   input  logic                            out_ready,
   output logic [IDX_W-1:0]                grant_id,
   output logic                            busy,
   output logic                            timeout_err
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             timeout_err_q, timeout_err_d;

   logic [IDX_W-1:0] pick_winner;
   logic             pick_any;
   logic             locked;
   logic             hs;
   logic [IDX_W-1:0] ptr_after_grant;

   rr_priority_picker #(
      .NUM_PORTS (NUM_PORTS)
   ) u_picker (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .winner  (pick_winner),
      .any_req (pick_any)
   );

   assign locked          = (state_q == ARB_LOCKED);
   assign hs              = out_valid & out_ready;
   assign ptr_after_grant = IDX_W'(rr_next(32'(grant_q), NUM_PORTS));

   assign grant_id    = grant_q;
   assign busy        = locked;
   assign timeout_err = timeout_err_q;

   // Output mux: only the locked port reaches the channel and sees ready.
   always_comb begin
      out_valid = 1'b0;
      out_tail  = 1'b0;
      out_flit  = '0;
      in_ready  = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (grant_q == IDX_W'(i)) begin
            out_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
            out_tail = in_tail[i];
         end
      end
      if (locked) begin
         out_valid          = in_valid[grant_q];
         in_ready[grant_q]  = out_ready;
      end
   end

   // Next-state: arbitration in IDLE, packet tracking and watchdog in LOCKED.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            wd_cnt_d = '0;
            if (pick_any) begin
               grant_d = pick_winner;
               state_d = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            if (hs) begin
               // A transfer always beats the watchdog on the same cycle.
               wd_cnt_d = '0;
               if (out_tail) begin
                  state_d  = ARB_IDLE;
                  rr_ptr_d = ptr_after_grant;
               end
            end else if (wd_cnt_q == WD_MAX) begin
               timeout_err_d = 1'b1;
               state_d       = ARB_IDLE;
               rr_ptr_d      = ptr_after_grant;
               wd_cnt_d      = '0;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARB_IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_flit_output_arbiter.sv
// Self-checking bench for flit_output_arbiter (4 ports, watchdog of 8 cycles).
module tb_flit_output_arbiter;

   localparam int unsigned NP = 4;
   localparam int unsigned FW = 64;
   localparam int unsigned TO = 8;

   typedef struct packed {
      logic [1:0]    port;
      logic [FW-1:0] flit;
      logic          tail;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NP-1:0]    in_valid;
   logic [NP*FW-1:0] in_flit;
   logic [NP-1:0]    in_tail;
   logic [NP-1:0]    in_ready;
   logic             out_valid;
   logic [FW-1:0]    out_flit;
   logic             out_tail;
   logic             out_ready;
   logic [1:0]       grant_id;
   logic             busy;
   logic             timeout_err;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   exp_t mon_e;

   flit_output_arbiter #(
      .NUM_PORTS   (NP),
      .FLIT_WIDTH  (FW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_flit     (in_flit),
      .in_tail     (in_tail),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_flit    (out_flit),
      .out_tail    (out_tail),
      .out_ready   (out_ready),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted flit must be the next expected one.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got port=%0d flit=%h tail=%b, required no transfer",
                     grant_id, out_flit, out_tail);
         end else begin
            mon_e = sb.pop_front();
            if ({grant_id, out_flit, out_tail} !== {mon_e.port, mon_e.flit, mon_e.tail}) begin
               bad++;
               $display("FAIL sb_flit: got port=%0d flit=%h tail=%b, required port=%0d flit=%h tail=%b",
                        grant_id, out_flit, out_tail, mon_e.port, mon_e.flit, mon_e.tail);
            end
         end
         total++;
         if (in_ready !== (4'b0001 << grant_id)) begin
            bad++;
            $display("FAIL sb_in_ready: got %b, required one-hot of port %0d", in_ready, grant_id);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic v, input logic [FW-1:0] f, input logic t);
      in_valid[p]          = v;
      in_flit[p*FW +: FW]  = f;
      in_tail[p]           = t;
   endtask

   task automatic push(input int p, input logic [FW-1:0] f, input logic t);
      exp_t e;
      e.port = 2'(p);
      e.flit = f;
      e.tail = t;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = '0; in_flit = '0; in_tail = '0; out_ready = 1'b0;
      step(); step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant: got %0d, required 0", grant_id); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b, required 0", timeout_err); end
      rst_n = 1'b1;
      set_port(0, 1'b1, 64'h55, 1'b0);
      step();
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b, required 1", busy); end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b, required 0", busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_ovalid: got %b, required 0", out_valid); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_async_iready: got %b, required 0000", in_ready); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_async_grant: got %0d, required 0", grant_id); end
      in_valid = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single_port();
      out_ready = 1'b1;
      set_port(2, 1'b1, 64'hA1, 1'b0);
      push(2, 64'hA1, 1'b0);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_bubble_busy: got %b, required 0", busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t2_bubble_ovalid: got %b, required 0", out_valid); end
      step();
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t2_busy: got %b, required 1", busy); end
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL t2_grant: got %0d, required 2", grant_id); end
      step();
      set_port(2, 1'b1, 64'hA2, 1'b0);
      push(2, 64'hA2, 1'b0);
      step();
      set_port(2, 1'b1, 64'hA3, 1'b1);
      push(2, 64'hA3, 1'b1);
      step();
      set_port(2, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_done_busy: got %b, required 0", busy); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL t2_drain: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int p = 0; p < 4; p++) set_port(p, 1'b1, 64'hB0 + 64'(p), 1'b1);
      for (int k = 0; k < 5; k++) push(order[k], 64'hB0 + 64'(order[k]), 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_bubble_%0d: got busy=%b, required 0", k, busy); end
         step();
         @(negedge clk);
         total++; if (grant_id !== 2'(order[k])) begin bad++; $display("FAIL t3_grant_%0d: got %0d, required %0d", k, grant_id, order[k]); end
         step();
      end
      in_valid = '0;
      @(negedge clk);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL t3_drain: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_out_stall();
      out_ready = 1'b0;
      set_port(1, 1'b1, 64'hC1, 1'b0);
      push(1, 64'hC1, 1'b0);
      step();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         total++; if (busy !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL t4_lock_%0d: got busy=%b grant=%0d, required busy=1 grant=1", i, busy, grant_id); end
         total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL t4_to_%0d: got %b, required 0", i, timeout_err); end
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL t4_to_hs: got %b, required 0", timeout_err); end
      step();
      set_port(1, 1'b1, 64'hC2, 1'b1);
      push(1, 64'hC2, 1'b1);
      @(negedge clk);
      total++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL t4_after: got to=%b busy=%b, required to=0 busy=1", timeout_err, busy); end
      step();
      set_port(1, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      total++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL t4_done: got busy=%b to=%b, required 0 0", busy, timeout_err); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL t4_drain: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_timeout();
      out_ready = 1'b1;
      set_port(1, 1'b1, 64'hD1, 1'b0);
      push(1, 64'hD1, 1'b0);
      step();
      @(negedge clk);
      total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL t5_grant: got %0d, required 1", grant_id); end
      step();
      set_port(1, 1'b0, 64'hD2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++; if (busy !== 1'b1 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL t5_stall_%0d: got busy=%b ovalid=%b to=%b, required 1 0 0", i, busy, out_valid, timeout_err);
         end
         step();
      end
      set_port(1, 1'b1, 64'hD2, 1'b0);
      set_port(2, 1'b1, 64'hE1, 1'b1);
      push(2, 64'hE1, 1'b1);
      @(negedge clk);
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL t5_pulse: got %b, required 1", timeout_err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_release: got busy=%b, required 0", busy); end
      step();
      @(negedge clk);
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL t5_pulse_end: got %b, required 0", timeout_err); end
      total++; if (grant_id !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL t5_next_grant: got %0d busy=%b, required 2 busy=1", grant_id, busy); end
      step();
      in_valid = '0;
      @(negedge clk);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL t5_drain: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      set_port(0, 1'b1, 64'hF0, 1'b1);
      set_port(3, 1'b1, 64'hF3, 1'b1);
      push(3, 64'hF3, 1'b1);
      push(0, 64'hF0, 1'b1);
      step();
      @(negedge clk);
      total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL t6_grant3: got %0d, required 3", grant_id); end
      step();
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_bubble: got busy=%b, required 0", busy); end
      step();
      @(negedge clk);
      total++; if (grant_id !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL t6_wrap: got %0d busy=%b, required 0 busy=1", grant_id, busy); end
      step();
      in_valid = '0;
      @(negedge clk);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL t6_drain: got %0d left, required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single_port();
      test_round_robin();
      test_out_stall();
      test_timeout();
      test_wrap();
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
